flt_add_engine: RTL
===================

FLT_ADD_ENGINE -- requirements
Module: flt_add_engine

Interface
REQ-001 Parameter OP_BASE, 8, byte address of operand 1 MSB; the four operand bytes are at OP_BASE..OP_BASE+3, MSB first.
REQ-002 Parameter RES_BASE, 12, byte address of result MSB; the result LSB is at RES_BASE+1.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  level handshake: high holds the engine idle; low runs one addition.
REQ-006 halt  out  1  high when the result is written; held until start returns high.
REQ-007 mem_addr  out  8  byte address to data memory.
REQ-008 mem_rd_data  in  8  combinational read data for mem_addr in the same cycle.
REQ-009 mem_wr_en  out  1  write strobe, sampled by memory on rising edge.
REQ-010 mem_wr_data  out  8  write data.

Function
REQ-011 Format SHALL be binary16: sign[15], exp[14:10] (bias 15), mant[9:0]. Hidden bit SHALL be |exp (exp 0 gives hidden 0, treated as exponent 1).
REQ-012 States: IDLE, LD0, LD1, LD2, LD3, ALIGN, ADD, NORM, ROUND, WR_HI, WR_LO, DONE.
REQ-013 IDLE->LD0 SHALL occur on the first rising edge with start low. If start is high in any state, the next state SHALL be IDLE.
REQ-014 LDn SHALL drive mem_addr=OP_BASE+n and capture mem_rd_data at the end of that cycle.
REQ-015 ALIGN SHALL right-shift the smaller-magnitude 11-bit significand by the exponent difference in one cycle.
- Guard, round and sticky bits are kept.
- If the difference exceeds 13, the shifted operand SHALL contribute only sticky.
REQ-016 ADD SHALL compute the effective sum or difference in sign-magnitude form.
- Result sign is the sign of the larger magnitude.
- An exact zero SHALL yield 0x0000.
REQ-017 NORM SHALL:
- right-shift once and increment the exponent on carry-out;
- otherwise left-shift one bit per cycle until the hidden bit is set or the exponent reaches 1.
- NORM SHALL take at most 11 cycles.
REQ-018 ROUND SHALL truncate guard/round/sticky (round toward zero), except as given in REQ-026.
REQ-019 A result exponent of 31 or more SHALL produce {sign, 5'h1F, 10'h000}. A denormal result SHALL keep exp 0 with the unnormalized mantissa.
REQ-020 Result writes:
- WR_HI: mem_addr=RES_BASE, mem_wr_data=result[15:8], mem_wr_en=1.
- WR_LO: mem_addr=RES_BASE+1, mem_wr_data=result[7:0], mem_wr_en=1.
- mem_wr_en SHALL be 0 in all other states.
REQ-021 In DONE, halt SHALL be 1. Total latency from the first start-low edge to halt high SHALL be 24 cycles or fewer.
REQ-022 Operands with exp 31 SHALL be processed arithmetically like finite values; NaN and Inf have no special handling.

Reset
REQ-023 reset high SHALL immediately force IDLE, even mid-operation.
REQ-024 During reset: halt=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and internal operand/result registers=0.
REQ-025 No partial result write SHALL occur after reset is asserted. Operation SHALL resume only through the REQ-013 handshake.

Configuration
REQ-026 With FLT_ROUND_NEAREST_EN defined, ROUND SHALL apply round-to-nearest-even using guard/round/sticky. A mantissa carry SHALL renormalize the result and increment the exponent, with overflow per REQ-019. Without the macro, truncation applies and the rounding logic SHALL be absent.

Verification
REQ-027 0x1A04 + 0x1A04 -> mem[12]=0x1E, mem[13]=0x04, halt high within 24 cycles.
REQ-028 0x4604 + 0x4604 -> 0x4A04.
REQ-029 0x3C00 + 0xBC00 -> 0x0000.
REQ-030 0x7BFF + 0x7BFF -> 0x7C00.
REQ-031 0x3C01 + 0x1000 -> 0x3C01 without FLT_ROUND_NEAREST_EN, 0x3C02 with it.
REQ-032 Pulse reset during NORM -> IDLE immediately, no mem_wr_en pulse, halt 0. Re-running REQ-027 afterwards gives the correct result.

Source files
------------

// File: rtl/flt_add_engine.sv
// flt_add_engine: multi-cycle binary16 adder. It fetches two operands from byte-wide
// data memory, adds them and writes the 16-bit result back. Rounding is toward zero.
// Defining FLT_ROUND_NEAREST_EN switches rounding to round-to-nearest-even.
module flt_add_engine #(
  parameter int unsigned OP_BASE  = 8,
  parameter int unsigned RES_BASE = 12
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  output logic       halt,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam logic [7:0] OpBase  = 8'(OP_BASE);
  localparam logic [7:0] ResBase = 8'(RES_BASE);

  typedef enum logic [3:0] {
    StIdle, StLd0, StLd1, StLd2, StLd3, StAlign, StAdd, StNorm, StRound, StWrHi, StWrLo, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] op_a_q, op_b_q, result_q;
  logic        sign_q, sub_q, zero_q;
  logic [5:0]  exp_q;
  logic [13:0] sig_l_q, sig_s_q;  // {hidden, mant[9:0], guard, round, sticky}
  logic [14:0] sum_q;             // sum frame plus carry-out bit

  // Align stage signals
  logic        a_big, sign_big;
  logic [14:0] op_big, op_small;
  logic [4:0]  exp_big, exp_small, exp_diff;
  logic [10:0] sig_big, sig_small;
  logic [27:0] shift_full;
  logic [13:0] sig_small_al;

  // Add / normalize / round stage signals
  logic [14:0] sum_add;
  logic [14:0] norm_sum, norm_shl;
  logic [5:0]  norm_exp;
  logic        norm_done;
  logic [10:0] rnd_sig;
  logic [5:0]  rnd_exp;
  logic [15:0] rnd_result;
`ifdef FLT_ROUND_NEAREST_EN
  logic        rnd_up;
  logic [11:0] rnd_sum;
`endif

  // Order operands by magnitude and shift the smaller one into the G/R/S frame
  always_comb begin
    // Magnitude order follows the raw exp/mant bits of binary16
    a_big     = op_a_q[14:0] >= op_b_q[14:0];
    op_big    = a_big ? op_a_q[14:0] : op_b_q[14:0];
    op_small  = a_big ? op_b_q[14:0] : op_a_q[14:0];
    sign_big  = a_big ? op_a_q[15] : op_b_q[15];
    exp_big   = (op_big[14:10] == 5'd0) ? 5'd1 : op_big[14:10];
    exp_small = (op_small[14:10] == 5'd0) ? 5'd1 : op_small[14:10];
    sig_big   = {|op_big[14:10], op_big[9:0]};
    sig_small = {|op_small[14:10], op_small[9:0]};
    exp_diff  = exp_big - exp_small;
    // Upper 14 bits are the shifted frame, lower 14 bits are what falls off
    shift_full = {sig_small, 17'd0} >> exp_diff;
    if (exp_diff > 5'd13) begin
      sig_small_al = {13'd0, |sig_small};
    end else begin
      sig_small_al = {shift_full[27:15], shift_full[14] | (|shift_full[13:0])};
    end
  end

  // Effective add or subtract; the larger magnitude is always the minuend
  always_comb begin
    if (sub_q) begin
      sum_add = {1'b0, sig_l_q} - {1'b0, sig_s_q};
    end else begin
      sum_add = {1'b0, sig_l_q} + {1'b0, sig_s_q};
    end
  end

  // One normalization step per cycle; left shifts stop at exponent 1 (denormal)
  always_comb begin
    norm_shl  = {sum_q[13:0], 1'b0};
    norm_sum  = sum_q;
    norm_exp  = exp_q;
    norm_done = 1'b0;
    if (zero_q) begin
      norm_done = 1'b1;
    end else if (sum_q[14]) begin
      // Carry-out: shift right, folding the two lowest bits into sticky
      norm_sum  = {1'b0, sum_q[14:2], sum_q[1] | sum_q[0]};
      norm_exp  = exp_q + 6'd1;
      norm_done = 1'b1;
    end else if (sum_q[13] || (exp_q == 6'd1)) begin
      norm_done = 1'b1;
    end else begin
      // Finishing in the same cycle as the last shift keeps NORM within 11 cycles
      norm_sum  = norm_shl;
      norm_exp  = exp_q - 6'd1;
      norm_done = norm_shl[13] || (exp_q == 6'd2);
    end
  end

  // Drop or round the G/R/S bits and pack the binary16 result
  always_comb begin
`ifdef FLT_ROUND_NEAREST_EN
    rnd_up  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    rnd_sum = {1'b0, sum_q[13:3]} + {11'd0, rnd_up};
    if (rnd_sum[11]) begin
      // Significand rolled over to 2.0: renormalize to 1.0 with exponent + 1
      rnd_sig = 11'h400;
      rnd_exp = exp_q + 6'd1;
    end else begin
      rnd_sig = rnd_sum[10:0];
      rnd_exp = exp_q;
    end
`else
    rnd_sig = sum_q[13:3];
    rnd_exp = exp_q;
`endif
    if (zero_q) begin
      rnd_result = 16'h0000;
    end else if (rnd_exp >= 6'd31) begin
      rnd_result = {sign_q, 5'h1F, 10'h000};
    end else begin
      // Hidden bit clear only happens at exponent 1, which encodes as exp field 0
      rnd_result = {sign_q, rnd_sig[10] ? rnd_exp[4:0] : 5'd0, rnd_sig[9:0]};
    end
  end

  // Next-state sequencing; start high always returns to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StLd0;
      StLd0:   state_d = StLd1;
      StLd1:   state_d = StLd2;
      StLd2:   state_d = StLd3;
      StLd3:   state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = norm_done ? StRound : StNorm;
      StRound: state_d = StWrHi;
      StWrHi:  state_d = StWrLo;
      StWrLo:  state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d = StIdle;
    end
  end

  // Memory interface and halt decoded from the current state
  always_comb begin
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    halt        = 1'b0;
    case (state_q)
      StLd0:  mem_addr = OpBase;
      StLd1:  mem_addr = OpBase + 8'd1;
      StLd2:  mem_addr = OpBase + 8'd2;
      StLd3:  mem_addr = OpBase + 8'd3;
      StWrHi: begin
        mem_addr    = ResBase;
        mem_wr_en   = 1'b1;
        mem_wr_data = result_q[15:8];
      end
      StWrLo: begin
        mem_addr    = ResBase + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = result_q[7:0];
      end
      StDone: halt = 1'b1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers, each loaded in the state that produces it
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      op_a_q   <= 16'd0;
      op_b_q   <= 16'd0;
      result_q <= 16'd0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      zero_q   <= 1'b0;
      exp_q    <= 6'd0;
      sig_l_q  <= 14'd0;
      sig_s_q  <= 14'd0;
      sum_q    <= 15'd0;
    end else begin
      case (state_q)
        StLd0: op_a_q[15:8] <= mem_rd_data;
        StLd1: op_a_q[7:0]  <= mem_rd_data;
        StLd2: op_b_q[15:8] <= mem_rd_data;
        StLd3: op_b_q[7:0]  <= mem_rd_data;
        StAlign: begin
          sign_q  <= sign_big;
          sub_q   <= op_a_q[15] ^ op_b_q[15];
          exp_q   <= {1'b0, exp_big};
          sig_l_q <= {sig_big, 3'b000};
          sig_s_q <= sig_small_al;
        end
        StAdd: begin
          sum_q  <= sum_add;
          zero_q <= (sum_add == 15'd0);
        end
        StNorm: begin
          sum_q <= norm_sum;
          exp_q <= norm_exp;
        end
        StRound: result_q <= rnd_result;
        default: ;
      endcase
    end
  end

endmodule
